// File: rtl/gbe_cpu_tx_master.sv
// gbe_cpu_tx_master
//   Wishbone master that pushes one packet at a time from a fabric word
//   stream into the GbE core's CPU attach port. It polls BUFFER_SIZES until
//   the previous CPU transmit has drained, copies the packet into the TX
//   buffer window with single-word writes, and then writes the TX size to
//   launch it. On any error the size write is never issued, so the core
//   never sends a partial packet.
//
// Ports
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wb_cyc_o .. wb_sel_o        classic Wishbone master request
//   wb_dat_i, wb_ack_i, wb_err_i slave response
//   s_data/s_valid/s_last/s_nbytes/s_ready  packet word stream
//                               (first byte in [31:24], nbytes 0 means 4)
//   busy                        packet in progress
//   done / err                  one-cycle pulses: launched / aborted
//   err_code                    01 timeout, 10 overflow, 11 wb_err (sticky)
//   pkt_count                   launched packets, wrapping
module gbe_cpu_tx_master #(
    parameter logic [31:0] BASE_ADDR               = 32'h0000_0000,
    parameter logic [31:0] TX_BUFFER_OFFSET        = 32'h0000_1000,
    parameter logic [31:0] REG_BUFFER_SIZES_OFFSET = 32'h0000_0018,
    parameter int          MAX_WORDS               = 512,
    parameter int          ACK_TIMEOUT             = 255,
    parameter int          POLL_GAP                = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    input  logic        s_last,
    input  logic [1:0]  s_nbytes,
    output logic        s_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] pkt_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_POLL, S_GAP, S_FETCH, S_WR, S_SIZE, S_ERR, S_FLUSH
    } state_t;

    state_t      state, state_d;
    logic        stb_q, stb_d;
    logic [15:0] tcnt;
    logic [15:0] gcnt;
    logic [9:0]  wcnt;
    logic [31:0] data_q;
    logic        last_q;
    logic [1:0]  nb_q;
    logic [1:0]  err_code_q;
    logic [15:0] pkt_count_q;
    logic        done_q;

    logic [1:0]  code_d;     // non-zero: error detected this cycle
    logic        latch_word;
    logic        wcnt_inc;
    logic        launch;
    logic        tmo;

    // Only the pending-size field of BUFFER_SIZES matters here.
    logic        unused_dat_bits;
    assign unused_dat_bits = ^{wb_dat_i[31:28], wb_dat_i[15:0]};

    // tcnt is zero in the first strobe cycle, so the bus gives up after
    // exactly ACK_TIMEOUT strobe cycles without a response.
    assign tmo = stb_q && (tcnt == 16'(ACK_TIMEOUT - 1));

    // Byte count of the packet: full words before the last, plus the last.
    logic [9:0]  wcnt_m1;
    logic [2:0]  nb_last;
    logic [11:0] size_bytes;
    assign wcnt_m1    = wcnt - 10'd1;
    assign nb_last    = (nb_q == 2'd0) ? 3'd4 : {1'b0, nb_q};
    assign size_bytes = {wcnt_m1, 2'b00} + {9'd0, nb_last};

    always_comb begin
        state_d    = state;
        stb_d      = stb_q;
        code_d     = 2'b00;
        latch_word = 1'b0;
        wcnt_inc   = 1'b0;
        launch     = 1'b0;
        s_ready    = 1'b0;
        case (state)
            S_IDLE: begin
                // Word is left on the stream until the buffer is free.
                if (s_valid) state_d = S_POLL;
            end
            S_POLL, S_WR, S_SIZE: begin
                // Strobe rises one cycle after entering a bus state, which
                // also guarantees an idle cycle between transactions.
                if (!stb_q) begin
                    stb_d = 1'b1;
                end else if (wb_err_i) begin
                    stb_d   = 1'b0;
                    code_d  = 2'b11;
                    state_d = S_ERR;
                end else if (wb_ack_i) begin
                    stb_d = 1'b0;
                    if (state == S_POLL) begin
                        state_d = (wb_dat_i[27:16] == 12'd0) ? S_FETCH : S_GAP;
                    end else if (state == S_WR) begin
                        wcnt_inc = 1'b1;
                        state_d  = last_q ? S_SIZE : S_FETCH;
                    end else begin
                        launch  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (tmo) begin
                    stb_d   = 1'b0;
                    code_d  = 2'b01;
                    state_d = S_ERR;
                end
            end
            S_GAP: begin
                if (gcnt == 16'(POLL_GAP - 1)) state_d = S_POLL;
            end
            S_FETCH: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    latch_word = 1'b1;
                    if (wcnt == 10'(MAX_WORDS)) begin
                        code_d  = 2'b10;
                        state_d = S_ERR;
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_ERR: begin
                // Nothing left to discard if the last word is already in.
                state_d = last_q ? S_IDLE : S_FLUSH;
            end
            S_FLUSH: begin
                s_ready = 1'b1;
                if (s_valid && s_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= S_IDLE;
            stb_q       <= 1'b0;
            tcnt        <= 16'd0;
            gcnt        <= 16'd0;
            wcnt        <= 10'd0;
            data_q      <= 32'd0;
            last_q      <= 1'b0;
            nb_q        <= 2'd0;
            err_code_q  <= 2'd0;
            pkt_count_q <= 16'd0;
            done_q      <= 1'b0;
        end else begin
            state  <= state_d;
            stb_q  <= stb_d;
            done_q <= launch;
            tcnt   <= stb_q ? tcnt + 16'd1 : 16'd0;
            gcnt   <= (state == S_GAP) ? gcnt + 16'd1 : 16'd0;
            if (state == S_IDLE) begin
                wcnt   <= 10'd0;
                last_q <= 1'b0;
            end else if (wcnt_inc) begin
                wcnt <= wcnt + 10'd1;
            end
            if (latch_word) begin
                data_q <= s_data;
                last_q <= s_last;
                nb_q   <= s_nbytes;
            end
            if (code_d != 2'b00) err_code_q <= code_d;
            if (launch) pkt_count_q <= pkt_count_q + 16'd1;
        end
    end

    // Request fields are decoded from registered state only, so they stay
    // stable for the whole strobe and read as zero whenever the bus is idle.
    always_comb begin
        wb_cyc_o = stb_q;
        wb_stb_o = stb_q;
        wb_we_o  = 1'b0;
        wb_adr_o = 32'd0;
        wb_dat_o = 32'd0;
        wb_sel_o = 4'h0;
        if (stb_q) begin
            case (state)
                S_POLL: begin
                    wb_adr_o = BASE_ADDR + REG_BUFFER_SIZES_OFFSET;
                    wb_sel_o = 4'hF;
                end
                S_WR: begin
                    wb_we_o  = 1'b1;
                    wb_adr_o = BASE_ADDR + TX_BUFFER_OFFSET + {20'd0, wcnt, 2'b00};
                    wb_dat_o = data_q;
                    wb_sel_o = 4'hF;
                end
                S_SIZE: begin
                    wb_we_o  = 1'b1;
                    wb_adr_o = BASE_ADDR + REG_BUFFER_SIZES_OFFSET;
                    wb_dat_o = {4'b0000, size_bytes, 16'h0000};
                    wb_sel_o = 4'b1100;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = done_q;
    assign err       = (state == S_ERR);
    assign err_code  = err_code_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_gbe_cpu_tx_master.sv
// Self-checking bench for gbe_cpu_tx_master. A Wishbone slave model answers
// the master; each packet's expected bus transactions are built from the
// packet contents into a queue and compared as the slave responds.
module tb_gbe_cpu_tx_master;
    localparam int ACK_TO = 255;
    localparam int PGAP   = 16;
    localparam int MAXW   = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i, wb_err_i;
    logic [31:0] s_data;
    logic        s_valid, s_last;
    logic [1:0]  s_nbytes;
    logic        s_ready, busy, done, err;
    logic [1:0]  err_code;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    gbe_cpu_tx_master #(
        .BASE_ADDR(32'h0), .TX_BUFFER_OFFSET(32'h1000),
        .REG_BUFFER_SIZES_OFFSET(32'h18), .MAX_WORDS(MAXW),
        .ACK_TIMEOUT(ACK_TO), .POLL_GAP(PGAP)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_nbytes(s_nbytes), .s_ready(s_ready),
        .busy(busy), .done(done), .err(err),
        .err_code(err_code), .pkt_count(pkt_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] poll_q[$];
    logic [31:0] pw[$];
    int  rd_lat = 1, wr_lat = 3, withhold = -1, bufw = 0;
    bit  err_on_size = 1'b0, bus_chk = 1'b1;
    int  cyc = 0, last_rd_cyc = -1000;
    int  n_done = 0, n_err = 0, hirun = 0, lastrun = 0, err_run = 0;
    int  model_pkts = 0;
    logic [31:0] last_size_dat = 32'd0, last_buf_adr = 32'd0;

    always @(posedge clk) cyc++;

    // Slave model and per-cycle compare process, sampled on the falling edge.
    initial begin
        logic        p_stb, p_resp, p_we;
        logic [31:0] p_adr, p_dat;
        logic [3:0]  p_sel;
        int          scnt, lat;
        bit          isbuf, issize;
        txn_t        e;
        p_stb = 0; p_resp = 0; p_we = 0; p_adr = 0; p_dat = 0; p_sel = 0; scnt = 0;
        wb_ack_i = 0; wb_err_i = 0; wb_dat_i = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wb_stb_o || wb_cyc_o) chk("cyc_eq_stb", 32'(wb_cyc_o), 32'(wb_stb_o));
                if (p_resp) chk("stb_drop_after_resp", 32'(wb_stb_o), 32'd0);
                else if (p_stb && wb_stb_o) begin
                    chk("adr_stable", wb_adr_o, p_adr);
                    chk("dat_stable", wb_dat_o, p_dat);
                    chk("sel_stable", 32'(wb_sel_o), 32'(p_sel));
                    chk("we_stable", 32'(wb_we_o), 32'(p_we));
                end
            end
            if (wb_stb_o) hirun++;
            else begin
                if (p_stb) lastrun = hirun;
                hirun = 0;
            end
            if (done) n_done++;
            if (err) begin n_err++; err_run = lastrun; end
            p_stb = wb_stb_o; p_we = wb_we_o; p_adr = wb_adr_o; p_dat = wb_dat_o; p_sel = wb_sel_o;

            wb_ack_i = 0; wb_err_i = 0; wb_dat_i = 0;
            if (wb_stb_o && !rst) begin
                scnt++;
                lat    = wb_we_o ? wr_lat : rd_lat;
                isbuf  = wb_we_o && wb_adr_o >= 32'h1000 && wb_adr_o < 32'h1800;
                issize = wb_we_o && wb_adr_o == 32'h18;
                if (scnt >= lat && !(isbuf && bufw == withhold)) begin
                    if (issize && err_on_size) wb_err_i = 1; else wb_ack_i = 1;
                    if (!wb_we_o) begin
                        wb_dat_i = (poll_q.size() > 0) ? poll_q.pop_front() : 32'd0;
                        if (bus_chk) chk("poll_spacing", 32'(cyc - last_rd_cyc >= PGAP + 1), 32'd1);
                        last_rd_cyc = cyc;
                    end
                    if (isbuf) begin bufw++; last_buf_adr = wb_adr_o; end
                    if (issize) last_size_dat = wb_dat_o;
                    if (bus_chk) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_txn_adr", wb_adr_o, 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            chk("txn_we", 32'(wb_we_o), 32'(e.we));
                            chk("txn_adr", wb_adr_o, e.adr);
                            chk("txn_sel", 32'(wb_sel_o), 32'(e.sel));
                            if (e.we) chk("txn_dat", wb_dat_o, e.dat);
                        end
                    end
                end
            end else begin
                scnt = 0;
            end
            p_resp = wb_ack_i | wb_err_i;
        end
    end

    // mode: 0 normal, 1 withhold ack on buffer write wh, 3 wb_err on size write.
    // Packets longer than MAXW overflow regardless of mode.
    task automatic run_pkt(input logic [1:0] nb, input int mode, input int nbusy, input int wh);
        int n, nw, code, c_done, c_err, t;
        txn_t e;
        n = pw.size();
        c_done = n_done; c_err = n_err;
        exp_q.delete(); poll_q.delete();
        bufw = 0; last_rd_cyc = -1000;
        withhold = (mode == 1) ? wh : -1;
        err_on_size = (mode == 3);
        for (int k = 0; k <= nbusy; k++) begin
            if (k < nbusy) poll_q.push_back(($urandom & 32'hF000_FFFF) | 32'h0040_0000);
            else           poll_q.push_back($urandom & 32'hF000_FFFF);
            e.we = 0; e.adr = 32'h18; e.dat = 0; e.sel = 4'hF;
            exp_q.push_back(e);
        end
        nw = (mode == 1) ? wh : ((n > MAXW) ? MAXW : n);
        for (int i = 0; i < nw; i++) begin
            e.we = 1; e.adr = 32'h1000 + 32'(4 * i); e.dat = pw[i]; e.sel = 4'hF;
            exp_q.push_back(e);
        end
        if (mode == 1)      code = 1;
        else if (n > MAXW)  code = 2;
        else if (mode == 3) code = 3;
        else                code = 0;
        if (code == 0 || code == 3) begin
            e.we = 1; e.adr = 32'h18; e.sel = 4'b1100;
            e.dat = {4'b0, 12'(4 * (n - 1) + ((nb == 2'd0) ? 4 : int'(nb))), 16'h0};
            exp_q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            s_valid = 1; s_data = pw[i]; s_last = (i == n - 1);
            s_nbytes = (i == n - 1) ? nb : 2'($urandom);
            t = 0;
            @(negedge clk);
            while (!s_ready && t < 3000) begin @(negedge clk); t++; end
            if (t >= 3000) begin
                chk("word_accept_timeout", 32'(i), 32'hFFFF_FFFF);
                break;
            end
            @(posedge clk); #1;
        end
        s_valid = 0; s_last = 0;
        t = 0;
        while (n_done == c_done && n_err == c_err && t < 3000) begin @(negedge clk); t++; end
        if (t >= 3000) chk("completion_timeout", 32'(t), 32'd0);
        repeat (3) @(negedge clk);
        if (code == 0) model_pkts++;
        chk("done_pulses", 32'(n_done - c_done), 32'(code == 0));
        chk("err_pulses", 32'(n_err - c_err), 32'(code != 0));
        if (code != 0) chk("err_code", 32'(err_code), 32'(code));
        chk("pkt_count", 32'(pkt_count), 32'(16'(model_pkts)));
        chk("exp_txn_drained", 32'(exp_q.size()), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        if (mode == 1) chk("timeout_len", 32'(err_run), 32'(ACK_TO));
        withhold = -1; err_on_size = 0;
    endtask

    initial begin
        int t, n, mode, wh;
        s_valid = 0; s_last = 0; s_data = 0; s_nbytes = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cyc", 32'(wb_cyc_o), 0);
        chk("rst_stb", 32'(wb_stb_o), 0);
        chk("rst_we", 32'(wb_we_o), 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_sel", 32'(wb_sel_o), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_err_code", 32'(err_code), 0);
        chk("rst_pkt_count", 32'(pkt_count), 0);
        rst = 0;
        repeat (2) @(negedge clk);

        // Directed 3-word packet, 10 bytes.
        pw = '{32'hAABBCCDD, 32'h11223344, 32'h55667788};
        run_pkt(2'd2, 0, 0, 0);
        chk("size_dat_literal", last_size_dat, 32'h000A_0000);
        chk("pkt_count_literal", 32'(pkt_count), 32'd1);

        // Buffer still busy for two polls.
        pw = '{32'h01020304, 32'h05060708};
        run_pkt(2'd0, 0, 2, 0);

        // Ack withheld on the second buffer write.
        pw = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        run_pkt(2'd3, 1, 0, 1);
        chk("err_code_timeout_literal", 32'(err_code), 32'd1);

        // 513 words: overflow on the last.
        pw.delete();
        for (int i = 0; i < MAXW + 1; i++) pw.push_back($urandom);
        run_pkt(2'd0, 0, 0, 0);
        chk("last_buf_adr_literal", last_buf_adr, 32'h0000_17FC);

        // Bus error on the size write, then a clean packet.
        pw = '{32'hCAFEF00D, 32'h0BADBEEF, 32'h12345678, 32'h9ABCDEF0};
        run_pkt(2'd1, 3, 0, 0);
        pw = '{32'h600DF00D};
        run_pkt(2'd0, 0, 0, 0);

        // Reset while a buffer write is on the bus.
        bus_chk = 0; withhold = 0; bufw = 0; exp_q.delete(); poll_q.delete();
        s_valid = 1; s_data = 32'hDEADBEEF; s_last = 0; s_nbytes = 0;
        t = 0;
        @(negedge clk);
        while (!(wb_stb_o && wb_we_o) && t < 1000) begin @(negedge clk); t++; end
        if (t >= 1000) chk("rst_wr_reach_timeout", 32'(t), 32'd0);
        s_valid = 0;
        rst = 1;
        @(posedge clk); #1;
        chk("midrst_cyc", 32'(wb_cyc_o), 0);
        chk("midrst_stb", 32'(wb_stb_o), 0);
        chk("midrst_we", 32'(wb_we_o), 0);
        chk("midrst_adr", wb_adr_o, 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_pkt_count", 32'(pkt_count), 0);
        model_pkts = 0;
        @(negedge clk);
        rst = 0;
        withhold = -1; bus_chk = 1;
        repeat (2) @(negedge clk);
        pw = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F};
        run_pkt(2'd3, 0, 1, 0);

        // Randomized packets.
        for (int p = 0; p < 12; p++) begin
            n = $urandom_range(1, 24);
            pw.delete();
            for (int i = 0; i < n; i++) pw.push_back($urandom);
            rd_lat = $urandom_range(1, 3);
            wr_lat = $urandom_range(1, 4);
            t = $urandom_range(0, 9);
            mode = (t < 6) ? 0 : ((t < 8) ? 1 : 3);
            wh = $urandom_range(0, n - 1);
            run_pkt(2'($urandom), mode, $urandom_range(0, 2), wh);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
